// File: rtl/alu_pkg.sv
// Shared ALU control definitions: multiplexer select codes, select type, sequencer states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    // 3-bit select driven to the ALU result multiplexer
    typedef logic [2:0] sel_t;

    localparam sel_t OP_A    = 3'd0;
    localparam sel_t OP_B    = 3'd1;
    localparam sel_t OP_C    = 3'd2;
    localparam sel_t OP_D    = 3'd3;
    localparam sel_t OP_E    = 3'd4;
    localparam sel_t OP_LAST = OP_E;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU command: drives operands/select, samples mux output after SETTLE cycles, returns result+flags.
// Latency: legal op responds SETTLE cycles after accept; illegal op responds right after accept.
// Backpressure: single command in flight; cmd_ready_o low until the response handshake completes.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_op_i,
    input  logic             cmd_acc_i,
    input  logic [WIDTH-1:0] cmd_a_i,
    input  logic [WIDTH-1:0] cmd_b_i,
    output logic [WIDTH-1:0] opa_o,
    output logic [WIDTH-1:0] opb_o,
    output logic [2:0]       ctrl_o,
    input  logic [WIDTH-1:0] result_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic             rsp_zero_o,
    output logic             rsp_neg_o,
    output logic             rsp_err_o,
    output logic [WIDTH-1:0] acc_o
);

    // Counter reload so the mux output is sampled exactly SETTLE edges after accept
    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    sel_t             ctrl_q, ctrl_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             err_q, err_d;

    // State and datapath registers; reset discards any command or pending response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            ctrl_q  <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            ctrl_q  <= ctrl_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; operands and select only change on a legal accept so the mux never glitches
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        ctrl_d  = ctrl_q;
        acc_d   = acc_q;
        data_d  = data_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    if (cmd_op_i <= OP_LAST) begin
                        opa_d   = cmd_acc_i ? acc_q : cmd_a_i;
                        opb_d   = cmd_b_i;
                        ctrl_d  = cmd_op_i;
                        cnt_d   = SETTLE_M1;
                        state_d = EXEC;
                    end else begin
                        // Illegal op: respond with error, leave operands/select/accumulator alone
                        data_d  = '0;
                        zero_d  = 1'b1;
                        neg_d   = 1'b0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    data_d  = result_i;
                    acc_d   = result_i;
                    zero_d  = (result_i == '0);
                    neg_d   = result_i[WIDTH-1];
                    err_d   = 1'b0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready_o = (state_q == IDLE) && rst_ni;
    assign rsp_valid_o = (state_q == RESP);
    assign opa_o       = opa_q;
    assign opb_o       = opb_q;
    assign ctrl_o      = ctrl_q;
    assign acc_o       = acc_q;
    assign rsp_data_o  = data_q;
    assign rsp_zero_o  = zero_q;
    assign rsp_neg_o   = neg_q;
    assign rsp_err_o   = err_q;

endmodule
